// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART transmit arbiter slice.
package uart_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam int unsigned DEFAULT_NUMBER_OF_BITS = 8;

  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream bus between N requesters and the arbiter feeding one UART transmitter.
interface uart_tx_arbiter_if #(
  parameter int unsigned NUM_REQUESTERS = 4,
  parameter int unsigned NUMBER_OF_BITS = uart_pkg::DEFAULT_NUMBER_OF_BITS
);
  localparam int unsigned GW = $clog2(NUM_REQUESTERS);

  logic [NUM_REQUESTERS-1:0]                     in_valid;
  logic [NUM_REQUESTERS-1:0][NUMBER_OF_BITS-1:0] in_data;
  logic [NUM_REQUESTERS-1:0]                     in_last;
  logic [NUM_REQUESTERS-1:0]                     in_ready;
  logic                                          out_valid;
  logic [NUMBER_OF_BITS-1:0]                     out_data;
  logic                                          out_ready;
  logic [GW-1:0]                                 grant_id;
  logic                                          busy;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, grant_id, busy
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, grant_id, busy
  );
endinterface

// File: rtl/uart_tx_arbiter_rr_priority_select.sv
// Combinational round-robin search: first set request at or after start_i, wrapping.
module rr_priority_select #(
  parameter int unsigned N = 4,
  localparam int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] start_i,
  output logic         found_o,
  output logic [W-1:0] idx_o
);
  int unsigned cand;

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    cand    = 0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = (32'(start_i) + i) % N;
      if (!found_o && req_i[W'(cand)]) begin
        found_o = 1'b1;
        idx_o   = W'(cand);
      end
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Locks one requester's message onto the UART byte stream; round-robin between messages.
// Optional idle-timeout release is built only when UART_TX_ARBITER_TIMEOUT_EN is defined.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQUESTERS = 4,
  parameter int unsigned NUMBER_OF_BITS = DEFAULT_NUMBER_OF_BITS,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input logic              clock,
  input logic              reset,
  uart_tx_arbiter_if.slave bus
);
  localparam int unsigned GW = $clog2(NUM_REQUESTERS);
  typedef logic [GW-1:0] idx_t;

  if (NUM_REQUESTERS < 2 || NUM_REQUESTERS > 8 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("uart_tx_arbiter: parameter out of range");
  end

  state_e state_q, state_d;
  idx_t   grant_q, grant_d;
  idx_t   last_q, last_d;
  idx_t   start, win;
  logic   found;
  logic   owner_valid, owner_last, xfer, timeout_hit;

  logic                      out_valid_c;
  logic [NUMBER_OF_BITS-1:0] out_data_c;
  logic [NUM_REQUESTERS-1:0] in_ready_c;

  assign start = idx_t'(wrap_inc(32'(last_q), NUM_REQUESTERS));

  rr_priority_select #(.N(NUM_REQUESTERS)) u_select (
    .req_i   (bus.in_valid),
    .start_i (start),
    .found_o (found),
    .idx_o   (win)
  );

  assign owner_valid = bus.in_valid[grant_q];
  assign owner_last  = bus.in_last[grant_q];

`ifdef UART_TX_ARBITER_TIMEOUT_EN
  localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CW-1:0] idle_cnt_q, idle_cnt_d;

  // Release on the edge where the count would reach TIMEOUT_CYCLES-1, so the
  // bus is free exactly TIMEOUT_CYCLES cycles after the last valid cycle.
  always_comb begin
    idle_cnt_d  = '0;
    timeout_hit = 1'b0;
    if (state_q == LOCKED && !owner_valid) begin
      if (idle_cnt_q == CW'(TIMEOUT_CYCLES - 2)) timeout_hit = 1'b1;
      else                                       idle_cnt_d  = idle_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) idle_cnt_q <= '0;
    else        idle_cnt_q <= idle_cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    out_valid_c = 1'b0;
    out_data_c  = '0;
    in_ready_c  = '0;
    xfer        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = LOCKED;
          grant_d = win;
        end
      end
      LOCKED: begin
        out_valid_c         = owner_valid;
        out_data_c          = bus.in_data[grant_q];
        in_ready_c[grant_q] = bus.out_ready;
        xfer                = owner_valid && bus.out_ready;
        if ((xfer && owner_last) || timeout_hit) begin
          state_d = IDLE;
          last_d  = grant_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= idx_t'(NUM_REQUESTERS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  assign bus.out_valid = out_valid_c;
  assign bus.out_data  = out_data_c;
  assign bus.in_ready  = in_ready_c;
  assign bus.grant_id  = grant_q;
  assign bus.busy      = (state_q == LOCKED);
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: message-level model plus directed scenarios.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned NB = DEFAULT_NUMBER_OF_BITS;
`ifdef UART_TX_ARBITER_TIMEOUT_EN
  localparam int unsigned TC = 16;
`else
  localparam int unsigned TC = 1024;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  uart_tx_arbiter_if #(.NUM_REQUESTERS(N), .NUMBER_OF_BITS(NB)) bus ();

  uart_tx_arbiter #(
    .NUM_REQUESTERS (N),
    .NUMBER_OF_BITS (NB),
    .TIMEOUT_CYCLES (TC)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  typedef struct { bit last; logic [NB-1:0] data; } beat_t;
  typedef struct { int r; int d; int cyc; } xfer_t;

  beat_t src[N][$];
  xfer_t log_q[$];
  bit    toggle_mode = 1'b0;
  bit    chk_en = 1'b0;
  int    cyc = 0;

  logic         snap_busy, snap_valid;
  logic [N-1:0] snap_rdy;
  logic [31:0]  snap_gid;
  int           snap_cyc;

  // Message-level model: owner (-1 when free), displayed grant, previous owner.
  int m_owner = -1;
  int m_grant = 0;
  int m_last  = N - 1;
  int m_idle  = 0;

  always @(posedge clock) begin
    bit picked;
    cyc++;
    if (!reset) begin
      m_owner = -1; m_grant = 0; m_last = N - 1; m_idle = 0;
    end else if (m_owner < 0) begin
      picked = 1'b0;
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (!picked && bus.in_valid[c]) begin
          picked = 1'b1; m_owner = c; m_grant = c; m_idle = 0;
        end
      end
    end else begin
      if (bus.in_valid[m_owner]) m_idle = 0;
      else                       m_idle++;
      if (bus.in_valid[m_owner] && bus.out_ready && bus.in_last[m_owner]) begin
        m_last = m_owner; m_owner = -1;
      end
`ifdef UART_TX_ARBITER_TIMEOUT_EN
      else if (m_idle == TC - 1) begin
        m_last = m_owner; m_owner = -1;
      end
`endif
    end
  end

  logic         e_busy, e_valid;
  logic [N-1:0] e_rdy;

  always @(negedge clock) begin
    if (chk_en) begin
      e_busy  = (m_owner >= 0);
      e_valid = (m_owner >= 0) ? bus.in_valid[m_owner] : 1'b0;
      e_rdy   = (m_owner >= 0) ? (N'(bus.out_ready) << m_owner) : '0;
      check("busy",      32'(bus.busy),      32'(e_busy));
      check("grant_id",  32'(bus.grant_id),  32'(m_grant));
      check("out_valid", 32'(bus.out_valid), 32'(e_valid));
      check("in_ready",  32'(bus.in_ready),  32'(e_rdy));
      if (e_valid) check("out_data", 32'(bus.out_data), 32'(bus.in_data[m_owner]));
      if (reset && bus.out_valid && bus.out_ready)
        log_q.push_back('{int'(bus.grant_id), int'(bus.out_data), cyc});
    end
  end

  task automatic drive();
    for (int r = 0; r < N; r++) begin
      if (src[r].size() > 0) begin
        bus.in_valid[r] = 1'b1;
        bus.in_data[r]  = src[r][0].data;
        bus.in_last[r]  = src[r][0].last;
      end else begin
        bus.in_valid[r] = 1'b0;
        bus.in_data[r]  = '0;
        bus.in_last[r]  = 1'b0;
      end
    end
    bus.out_ready = toggle_mode ? ~bus.out_ready : 1'b1;
  endtask

  task automatic cycle();
    logic [N-1:0] acc;
    @(negedge clock);
    acc        = bus.in_valid & bus.in_ready & {N{reset}};
    snap_busy  = bus.busy;
    snap_valid = bus.out_valid;
    snap_rdy   = bus.in_ready;
    snap_gid   = 32'(bus.grant_id);
    snap_cyc   = cyc;
    @(posedge clock);
    #1;
    for (int r = 0; r < N; r++) if (acc[r]) void'(src[r].pop_front());
    drive();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    toggle_mode = 1'b0;
    for (int r = 0; r < N; r++) src[r].delete();
    drive();
    cycle();
    cycle();
    reset = 1'b1;
    log_q.delete();
  endtask

  task automatic push(input int r, input int d, input bit last);
    src[r].push_back('{last, NB'(d)});
  endtask

  task automatic wait_log(input int n, input int budget, input string name);
    int k = 0;
    while (log_q.size() < n && k < budget) begin
      cycle();
      k++;
    end
    check({name, "_bytes_seen"}, 32'(log_q.size() >= n), 32'd1);
  endtask

  task automatic expect_log(input int idx, input int r, input int d, input string name);
    if (idx < log_q.size()) begin
      check({name, "_owner"}, 32'(log_q[idx].r), 32'(r));
      check({name, "_data"},  32'(log_q[idx].d), 32'(d));
    end else begin
      check({name, "_present"}, 32'(log_q.size()), 32'(idx + 1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive();
    @(posedge clock);
    #1;
    chk_en = 1'b1;

    // Reset values on the first cycle after release
    do_reset();
    drive();
    cycle();
    check("rst_busy",      32'(snap_busy),  32'd0);
    check("rst_out_valid", 32'(snap_valid), 32'd0);
    check("rst_in_ready",  32'(snap_rdy),   32'd0);
    check("rst_grant_id",  snap_gid,        32'd0);

    // Two 3-byte messages from requesters 0 and 2
    do_reset();
    push(0, 'h41, 0); push(0, 'h42, 0); push(0, 'h43, 1);
    push(2, 'h61, 0); push(2, 'h62, 0); push(2, 'h63, 1);
    drive();
    wait_log(6, 20, "two_msg");
    expect_log(0, 0, 'h41, "two_msg0");
    expect_log(1, 0, 'h42, "two_msg1");
    expect_log(2, 0, 'h43, "two_msg2");
    expect_log(3, 2, 'h61, "two_msg3");
    expect_log(4, 2, 'h62, "two_msg4");
    expect_log(5, 2, 'h63, "two_msg5");
    if (log_q.size() >= 4) check("two_msg_gap", 32'(log_q[3].cyc - log_q[2].cyc), 32'd2);
    check("model_last_owner_a", 32'(m_last), 32'd2);

    // All four requesters continuously offering single-byte messages
    do_reset();
    for (int m = 0; m < 2; m++)
      for (int r = 0; r < N; r++) push(r, 'h80 + 16 * r + m, 1);
    drive();
    wait_log(8, 40, "rr");
    for (int i = 0; i < 8; i++) expect_log(i, i % 4, 'h80 + 16 * (i % 4) + i / 4, "rr");
    check("model_last_owner_b", 32'(m_last), 32'd3);

    // Owner pauses mid-message while another requester waits
    do_reset();
    push(1, 'h10, 0);
    push(3, 'h33, 1);
    drive();
    wait_log(1, 10, "pause_first");
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("pause_busy",  32'(snap_busy), 32'd1);
      check("pause_grant", snap_gid,       32'd1);
    end
    push(1, 'h11, 1);
    drive();
    wait_log(3, 20, "pause");
    expect_log(0, 1, 'h10, "pause0");
    expect_log(1, 1, 'h11, "pause1");
    expect_log(2, 3, 'h33, "pause2");

    // out_ready alternating during a 4-byte message
    do_reset();
    toggle_mode = 1'b1;
    push(0, 'hA0, 0); push(0, 'hA1, 0); push(0, 'hA2, 0); push(0, 'hA3, 1);
    drive();
    wait_log(4, 30, "toggle");
    repeat (4) cycle();
    toggle_mode = 1'b0;
    check("toggle_count", 32'(log_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) expect_log(i, 0, 'hA0 + i, "toggle");

    // Back-to-back single-byte messages from one requester
    do_reset();
    push(0, 'h51, 1); push(0, 'h52, 1); push(0, 'h53, 1);
    drive();
    wait_log(3, 20, "b2b");
    for (int i = 0; i < 3; i++) expect_log(i, 0, 'h51 + i, "b2b");
    if (log_q.size() >= 3) begin
      check("b2b_gap1", 32'(log_q[1].cyc - log_q[0].cyc), 32'd2);
      check("b2b_gap2", 32'(log_q[2].cyc - log_q[1].cyc), 32'd2);
    end

    // Reset while the second byte of a message is on the bus
    do_reset();
    push(0, 'hB0, 0); push(0, 'hB1, 0); push(0, 'hB2, 1);
    push(1, 'hC0, 1);
    drive();
    wait_log(1, 10, "mid_rst_first");
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    src[0].delete();
    push(0, 'hD0, 1);
    drive();
    cycle();
    check("mid_rst_busy",      32'(snap_busy),  32'd0);
    check("mid_rst_out_valid", 32'(snap_valid), 32'd0);
    wait_log(3, 20, "mid_rst");
    expect_log(0, 0, 'hB0, "mid_rst0");
    expect_log(1, 0, 'hD0, "mid_rst1");
    expect_log(2, 1, 'hC0, "mid_rst2");

`ifdef UART_TX_ARBITER_TIMEOUT_EN
    // Stalled owner is released TC cycles after its last valid cycle
    begin
      int t_last;
      int t_free;
      int k;
      do_reset();
      push(0, 'hE0, 0);
      push(1, 'hF0, 1);
      drive();
      wait_log(1, 10, "timeout_first");
      t_last = (log_q.size() > 0) ? log_q[0].cyc : 0;
      t_free = -1;
      k = 0;
      while (t_free < 0 && k < 40) begin
        cycle();
        if (!snap_busy) t_free = snap_cyc;
        k++;
      end
      check("timeout_release_delay", 32'(t_free - t_last), 32'd16);
      wait_log(2, 10, "timeout");
      expect_log(1, 1, 'hF0, "timeout_next");
    end
`endif

    repeat (2) cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
